psum_row_collector: RTL and testbench

- Output-side stage directly downstream of the global PE set.
- Consumes one partial-sum stream per PE row and, for each output position, adds the psums of the active rows into one wide result.
- Buffers results in a small output FIFO and streams them to the output writer with valid/ready backpressure.
- Runs on the bus clock domain.

---
 rtl/psum_row_collector.sv | 159 +++++++++++++++
 tb/tb_psum_row_collector.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_row_collector.sv
// ============================================================================
// Module   : psum_row_collector
// Purpose  : Sums the psums of the active PE rows and queues the results in a
//            first-word fall-through output FIFO. Build with PSUM_SAT_EN
//            defined to clamp each sum to the signed DATA_WIDTH range.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_row_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROW    = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [7:0]                    kernel_size,
  input  logic [15:0]                   num_out,
  input  logic [NUM_ROW*DATA_WIDTH-1:0] psum_in,
  input  logic [NUM_ROW-1:0]            psum_valid,
  output logic [NUM_ROW-1:0]            psum_ready,
  output logic [ACC_WIDTH-1:0]          out_data,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  state_t                  state, state_nxt;
  logic [NUM_ROW-1:0]      act, act_nxt, hold_full;
  logic [DATA_WIDTH-1:0]   hold_val [NUM_ROW];
  logic [15:0]             num_out_q, fire_cnt;
  logic [7:0]              ks_eff;
  logic                    all_full, fire, fire_last, done_nxt, pop;
  logic [ACC_WIDTH-1:0]    sum_full, push_data;
  logic [ACC_WIDTH:0]      mem [FIFO_DEPTH];
  logic [PTR_W:0]          wr_ptr, rd_ptr;
  logic                    fifo_empty, fifo_full;

  assign ks_eff = (kernel_size == 8'd0) ? 8'd1 : kernel_size;

  generate
    for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
      assign act_nxt[r]    = (ks_eff > 8'(r));
      assign psum_ready[r] = (state == COLLECT) & act[r] & ~hold_full[r];

      always_ff @(posedge clk) begin
        if (rst) begin
          hold_full[r] <= 1'b0;
          hold_val[r]  <= '0;
        end else if (fire) begin
          hold_full[r] <= 1'b0;
        end else if (psum_valid[r] & psum_ready[r]) begin
          hold_full[r] <= 1'b1;
          hold_val[r]  <= psum_in[r*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  endgenerate

  assign all_full  = &(hold_full | ~act);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fire      = (state == COLLECT) & all_full & ~fifo_full;
  assign fire_last = (fire_cnt == num_out_q - 16'd1);
  assign pop       = out_valid & out_ready;

  always_comb begin
    sum_full = '0;
    for (int r = 0; r < NUM_ROW; r++) begin
      if (act[r]) begin
        sum_full = sum_full +
          {{(ACC_WIDTH-DATA_WIDTH){hold_val[r][DATA_WIDTH-1]}}, hold_val[r]};
      end
    end
  end

`ifdef PSUM_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    push_data = sum_full;
    if ($signed(sum_full) > $signed(SAT_MAX))      push_data = SAT_MAX;
    else if ($signed(sum_full) < $signed(SAT_MIN)) push_data = SAT_MIN;
  end
`else
  assign push_data = sum_full;
`endif

  // Head is gated by empty so out_data/out_last read zero after reset.
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]][ACC_WIDTH-1:0];
  assign out_last  = ~fifo_empty & mem[rd_ptr[PTR_W-1:0]][ACC_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fire) begin
        mem[wr_ptr[PTR_W-1:0]] <= {fire_last, push_data};
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      act       <= '0;
      num_out_q <= '0;
      fire_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (state == IDLE && start) begin
        act       <= act_nxt;
        num_out_q <= num_out;
        fire_cnt  <= '0;
      end else if (fire) begin
        fire_cnt <= fire_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = (num_out == 16'd0) ? DRAIN : COLLECT;
      COLLECT: if (fire && fire_last) state_nxt = DRAIN;
      DRAIN: begin
        if (fifo_empty) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_psum_row_collector.sv
// ============================================================================
// Module   : tb_psum_row_collector
// Purpose  : Directed scoreboard bench for psum_row_collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psum_row_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  kernel_size = '0;
  logic [15:0] num_out = '0;
  logic [63:0] psum_in = '0;
  logic [3:0]  psum_valid = '0;
  logic [3:0]  psum_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  psum_row_collector dut (
    .clk(clk), .rst(rst), .start(start), .kernel_size(kernel_size),
    .num_out(num_out), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every accepted output is popped against the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got last=%0b data=%0h", out_last, out_data);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          failures++;
          $display("FAIL output got last=%0b data=%0h exp last=%0b data=%0h",
                   out_last, out_data, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] ks, input logic [15:0] n);
    kernel_size = ks;
    num_out = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offers vals on the masked rows and holds each until its handshake.
  task automatic send(input logic [3:0] mask, input logic [63:0] vals);
    logic [3:0] pending, acc;
    int n;
    psum_in = vals;
    pending = mask;
    psum_valid = pending;
    n = 0;
    while (pending != 4'b0 && n < 200) begin
      @(negedge clk);
      acc = pending & psum_ready;
      tick();
      pending = pending & ~acc;
      psum_valid = pending;
      n++;
    end
    psum_valid = 4'b0;
    if (pending != 4'b0) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=%0b exp=0", pending);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk(name, {63'd0, done}, 64'd1);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_ready", {60'd0, psum_ready}, 64'd0);
    chk("reset_out_data", {31'd0, out_last, out_data}, 64'd0);
    rst = 1'b0;
    tick();

    // Basic sum over three rows
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 32'd6});
    exp_q.push_back({1'b1, 32'd60});
    do_start(8'd3, 16'd2);
    chk("basic_ready_mask", {60'd0, psum_ready}, 64'h7);
    send(4'b0111, {16'd0, 16'd3, 16'd2, 16'd1});
    send(4'b0111, {16'd0, 16'd30, 16'd20, 16'd10});
    wait_done("basic_done");
    chk("basic_drained", exp_q.size(), 64'd0);
    tick();

    // Skewed arrival: row 2 late
    exp_q.push_back({1'b1, 32'd100});
    do_start(8'd4, 16'd1);
    send(4'b1011, {16'hFFFD, 16'd100, 16'd7, 16'hFFFC});
    for (int i = 0; i < 4; i++) chk("skew_wait_ready", {60'd0, psum_ready}, 64'h4);
    tick();
    send(4'b0100, {16'hFFFD, 16'd100, 16'd7, 16'hFFFC});
    chk("skew_fire_cycle_valid", {63'd0, out_valid}, 64'd0);
    tick();
    chk("skew_result_cycle_valid", {63'd0, out_valid}, 64'd1);
    wait_done("skew_done");
    tick();

    // Backpressure: single row, FIFO fills to depth
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) exp_q.push_back({(i == 11), 32'(i)});
    do_start(8'd1, 16'd12);
    fork
      begin
        for (int i = 0; i < 12; i++) send(4'b0001, {48'd0, 16'(i)});
      end
      begin
        repeat (40) tick();
        chk("bp_row0_stalled", {63'd0, psum_ready[0]}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_head", {31'd0, out_last, out_data}, 64'd0);
        chk("bp_queue_intact", exp_q.size(), 64'd12);
        out_ready = 1'b1;
      end
    join
    wait_done("bp_done");
    chk("bp_drained", exp_q.size(), 64'd0);
    tick();

    // Clamp: kernel_size 9 uses four rows, 0 uses row 0
    exp_q.push_back({1'b1, 32'd10});
    do_start(8'd9, 16'd1);
    chk("clamp9_ready", {60'd0, psum_ready}, 64'hF);
    send(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1});
    wait_done("clamp9_done");
    tick();
    exp_q.push_back({1'b1, 32'd5});
    do_start(8'd0, 16'd1);
    chk("clamp0_ready", {60'd0, psum_ready}, 64'h1);
    send(4'b0001, {16'd9, 16'd9, 16'd9, 16'd5});
    wait_done("clamp0_done");
    tick();

    // num_out == 0: done two cycles after start, no output
    do_start(8'd2, 16'd0);
    chk("zero_done_early", {63'd0, done}, 64'd0);
    chk("zero_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("zero_done", {63'd0, done}, 64'd1);
    chk("zero_idle", {63'd0, busy}, 64'd0);
    chk("zero_no_output", {63'd0, out_valid}, 64'd0);
    tick();

    // Reset mid-job with queued results and a partial hold
    out_ready = 1'b0;
    do_start(8'd2, 16'd10);
    for (int i = 0; i < 3; i++) send(4'b0011, {32'd0, 16'd1, 16'd1});
    tick();
    send(4'b0001, {48'd0, 16'd1});
    chk("mid_pre_reset_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_ready", {60'd0, psum_ready}, 64'd0);
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    exp_q.push_back({1'b1, 32'hFFFF_FFFE});
    do_start(8'd2, 16'd1);
    send(4'b0011, {32'd0, 16'hFFF7, 16'd7});
    wait_done("mid_new_job_done");
    tick();

    // Large sum: saturation only in the PSUM_SAT_EN build
`ifdef PSUM_SAT_EN
    exp_q.push_back({1'b1, 32'd32767});
`else
    exp_q.push_back({1'b1, 32'd65534});
`endif
    do_start(8'd2, 16'd1);
    send(4'b0011, {32'd0, 16'd32767, 16'd32767});
    wait_done("sat_done");
    tick();
    chk("final_drained", exp_q.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
